// File: rtl/converter_bin2gray_arbiter.sv
// Round-robin arbiter that shares one binary-to-Gray converter among several
// valid/ready requesters and presents the result in a one-entry output register.

module converter_bin2gray #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] bin_i,
  output logic [Width-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

module converter_bin2gray_arbiter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQUESTERS-1:0]            req_valid,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQUESTERS-1:0]            req_ready,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [ID_WIDTH-1:0]                  out_id
);

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ID_WIDTH-1:0]   out_id_q;
  logic [ID_WIDTH-1:0]   prio_q, prio_d;

  logic                  can_accept;
  logic                  found;
  logic                  grant;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH-1:0]   scan_idx;
  int unsigned           scan_pos;
  logic [DATA_WIDTH-1:0] conv_bin;
  logic [DATA_WIDTH-1:0] conv_gray;

  assign can_accept = !out_valid_q || out_ready;

  // Scan from the priority pointer upward, wrapping explicitly so that a
  // non-power-of-two requester count never indexes past the last requester.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
      scan_pos = 32'(prio_q) + k;
      if (scan_pos >= NUM_REQUESTERS) begin
        scan_pos = scan_pos - NUM_REQUESTERS;
      end
      scan_idx = ID_WIDTH'(scan_pos);
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign grant = found && can_accept && rst_n;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    if (grant_idx == ID_WIDTH'(NUM_REQUESTERS - 1)) begin
      prio_d = '0;
    end else begin
      prio_d = grant_idx + ID_WIDTH'(1);
    end
  end

  assign conv_bin = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  converter_bin2gray #(
    .Width (DATA_WIDTH)
  ) u_conv (
    .bin_i  (conv_bin),
    .gray_o (conv_gray)
  );

  // A grant loads even when the old word drains in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      prio_q      <= '0;
    end else if (grant) begin
      out_valid_q <= 1'b1;
      out_data_q  <= conv_gray;
      out_id_q    <= grant_idx;
      prio_q      <= prio_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_converter_bin2gray_arbiter.sv
// Randomised bench for converter_bin2gray_arbiter: a 4-requester and a
// 3-requester instance checked every cycle against a behavioural model.

module tb_converter_bin2gray_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic out_ready;

  logic [3:0]  a_req_valid, a_req_ready;
  logic [31:0] a_req_data;
  logic        a_out_valid;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_id;

  logic [2:0]  b_req_valid, b_req_ready;
  logic [23:0] b_req_data;
  logic        b_out_valid;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_id;

  logic [7:0] dat [2][4];
  logic [3:0] vld [2];

  assign a_req_valid = vld[0];
  assign a_req_data  = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
  assign b_req_valid = vld[1][2:0];
  assign b_req_data  = {dat[1][2], dat[1][1], dat[1][0]};

  converter_bin2gray_arbiter #(
    .DATA_WIDTH     (8),
    .NUM_REQUESTERS (4)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (a_req_valid),
    .req_data  (a_req_data),
    .req_ready (a_req_ready),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_data  (a_out_data),
    .out_id    (a_out_id)
  );

  converter_bin2gray_arbiter #(
    .DATA_WIDTH     (8),
    .NUM_REQUESTERS (3)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_req_valid),
    .req_data  (b_req_data),
    .req_ready (b_req_ready),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_data  (b_out_data),
    .out_id    (b_out_id)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state per instance.
  int         nreq   [2] = '{4, 3};
  int         m_prio [2];
  logic       m_ov   [2];
  logic [7:0] m_od   [2];
  int         m_id   [2];
  int         last_g [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] gray_ref(input logic [7:0] b);
    logic [7:0] g;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) g[i] = b[i];
      else        g[i] = b[i] ^ b[i+1];
    end
    return g;
  endfunction

  task automatic step(input logic r, input logic o);
    int         g   [2];
    logic [3:0] rdy [2];
    rst_n     = r;
    out_ready = o;
    #1;
    rdy[0] = a_req_ready;
    rdy[1] = {1'b0, b_req_ready};
    for (int inst = 0; inst < 2; inst++) begin
      g[inst] = -1;
      if (r && (!m_ov[inst] || o)) begin
        for (int k = 0; k < nreq[inst]; k++) begin
          int idx;
          idx = (m_prio[inst] + k) % nreq[inst];
          if (g[inst] < 0 && vld[inst][idx]) g[inst] = idx;
        end
      end
      check_val($sformatf("req_ready[%0d]", inst), 32'(rdy[inst]),
                g[inst] >= 0 ? 32'(1 << g[inst]) : 32'd0);
    end
    @(posedge clk);
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      if (!r) begin
        m_ov[inst] = 1'b0; m_od[inst] = 8'h00; m_id[inst] = 0; m_prio[inst] = 0;
      end else if (g[inst] >= 0) begin
        m_ov[inst]   = 1'b1;
        m_od[inst]   = gray_ref(dat[inst][g[inst]]);
        m_id[inst]   = g[inst];
        m_prio[inst] = (g[inst] + 1) % nreq[inst];
      end else if (o) begin
        m_ov[inst] = 1'b0;
      end
      last_g[inst] = g[inst];
    end
    check_val("out_valid[0]", 32'(a_out_valid), 32'(m_ov[0]));
    check_val("out_data[0]",  32'(a_out_data),  32'(m_od[0]));
    check_val("out_id[0]",    32'(a_out_id),    32'(m_id[0]));
    check_val("out_valid[1]", 32'(b_out_valid), 32'(m_ov[1]));
    check_val("out_data[1]",  32'(b_out_data),  32'(m_od[1]));
    check_val("out_id[1]",    32'(b_out_id),    32'(m_id[1]));
    @(negedge clk);
  endtask

  // Granted requesters present a fresh word; valids stay as set.
  task automatic refresh_granted();
    for (int inst = 0; inst < 2; inst++) begin
      if (last_g[inst] >= 0) dat[inst][last_g[inst]] = 8'($urandom);
    end
  endtask

  logic [7:0] words [5] = '{8'hB5, 8'h00, 8'hFF, 8'h80, 8'h03};
  logic [7:0] grays [5] = '{8'hEF, 8'h00, 8'h80, 8'hC0, 8'h02};

  initial begin
    for (int inst = 0; inst < 2; inst++) begin
      m_prio[inst] = 0; m_ov[inst] = 1'b0; m_od[inst] = 8'h00; m_id[inst] = 0;
      last_g[inst] = -1;
      for (int i = 0; i < 4; i++) dat[inst][i] = 8'($urandom);
    end
    vld[0] = 4'b1111;
    vld[1] = 4'b0101;

    // Reset with every request active, then first grant goes to requester 0.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    refresh_granted();

    // Single requester 2 on the 4-way instance with known conversions.
    vld[0] = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      dat[0][2] = words[i];
      step(1'b1, 1'b1);
      check_val($sformatf("gray_const[%0d]", i), 32'(a_out_data), 32'(grays[i]));
      refresh_granted();
    end

    // Continuous requests on all lanes: round-robin at full throughput.
    vld[0] = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1);
      refresh_granted();
    end

    // Backpressure for three cycles, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    refresh_granted();

    // Reset while stalled: the held word is dropped and priority restarts at 0.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    refresh_granted();

    // Random traffic; a requester keeps its word until granted.
    for (int n = 0; n < 400; n++) begin
      for (int inst = 0; inst < 2; inst++) begin
        for (int i = 0; i < nreq[inst]; i++) begin
          if (i == last_g[inst]) begin
            vld[inst][i] = 1'($urandom_range(0, 1));
            dat[inst][i] = 8'($urandom);
          end else if (!vld[inst][i]) begin
            vld[inst][i] = ($urandom_range(0, 2) != 0);
            dat[inst][i] = 8'($urandom);
          end
        end
      end
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/converter_bin2gray_arbiter.md
# converter_bin2gray_arbiter

Round-robin arbiter and sequencer that shares a single binary-to-Gray converter between `NUM_REQUESTERS` independent requesters. Each requester presents a binary word on a valid/ready handshake. The block grants at most one requester per cycle, converts the granted word, and presents the Gray result with the requester index on a registered valid/ready output. It sits between the analyser's counter/pointer producers and any consumer that needs Gray-coded values, replacing per-producer converter instances.

## Interface
- `DATA_WIDTH`, default 8: width of the binary input and Gray output words. Must be ≥ 2.
- `NUM_REQUESTERS`, default 4: number of requesters. Must be ≥ 2.
- `ID_WIDTH`, default `$clog2(NUM_REQUESTERS)`: width of `out_id`. Derived; do not override.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: synchronous reset, active low.
- `req_valid` input `NUM_REQUESTERS`: bit i high means requester i presents a word.
- `req_data` input `NUM_REQUESTERS*DATA_WIDTH`: flattened binary words. Requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` output `NUM_REQUESTERS`: one-hot or zero grant. Bit i high means requester i's word is accepted this cycle.
- `out_valid` output 1: the output register holds a converted word.
- `out_ready` input 1: the consumer accepts the output word this cycle.
- `out_data` output `DATA_WIDTH`: Gray-coded word.
- `out_id` output `ID_WIDTH`: index of the requester that supplied `out_data`.

## Operation
- Conversion: the block instantiates one `converter_bin2gray`, with its input muxed from the granted requester's word. Conversion rule: Gray = bin ^ (bin >> 1), with the MSB passed through unchanged.
- Output register (one entry) holds `out_valid`, `out_data` and `out_id`.
- `can_accept` = `!out_valid || out_ready`. No grant is issued when `can_accept` is low.
- Arbitration is round-robin over the requesters with `req_valid` high:
  - A priority pointer `prio` (`ID_WIDTH` bits) names the highest-priority index.
  - Search order is `prio`, `prio+1`, … wrapping modulo `NUM_REQUESTERS`.
  - The first valid requester found is granted.
- `req_ready` is combinational from `req_valid`, `prio` and `can_accept`. Exactly one bit is high iff `can_accept` and any `req_valid` bit is high; otherwise all bits are zero.
- On a grant to index g:
  - the output register loads `out_data` = Gray of that requester's word and `out_id` = g, and sets `out_valid` = 1;
  - `prio` ← (g+1) mod `NUM_REQUESTERS`, with explicit wrap so that non-power-of-two `NUM_REQUESTERS` works.
- If `out_ready` is high and there is no grant, `out_valid` ← 0 and `prio` is unchanged.
- If there are no requests, `prio` holds its value. The pointer only advances on a grant, so an idle requester never loses its turn.
- Stall: while `out_valid && !out_ready`, the values `out_data` and `out_id` stay stable, and `req_ready` is all zero.
- Requesters must not make `req_valid` depend on `req_ready`. A requester holds its word stable until it is granted.
- Simultaneous drain and load (`out_valid`, `out_ready` and a new grant in the same cycle): the new word replaces the old one and `out_valid` stays 1. This gives full throughput of one word per cycle.

## Timing
- Reset (`rst_n` low at a rising edge): `out_valid` = 0, `out_data` = 0, `out_id` = 0, `prio` = 0. `req_ready` is all zero while `rst_n` is low.
- Reset asserted mid-operation discards any pending output word. No grant is issued in a cycle in which `rst_n` is low.
- Latency: a word granted at edge N appears on `out_data`/`out_valid` after edge N, i.e. one cycle.
- Throughput: one conversion per cycle while `out_ready` is held high.
- Fairness: under continuous requests from k requesters, each one is granted once every k grants.

## Test plan
- Reset: drive `rst_n` = 0 for 2 cycles with all requests active → `out_valid` = 0, `out_data` = 0, `out_id` = 0, `req_ready` = 0; the first grant after release goes to requester 0.
- Single requester: only requester 2 is valid with word 8'hB5 and `out_ready` = 1 → `req_ready` = 4'b0100, and one cycle later `out_data` = 8'hEF, `out_id` = 2. Further words 8'h00→8'h00, 8'hFF→8'h80, 8'h80→8'hC0, 8'h03→8'h02.
- Round-robin: all 4 requesters valid continuously with `out_ready` = 1 → grant order 0,1,2,3,0,1…, `out_valid` high every cycle, and `out_data` matches each requester's word.
- Backpressure: `out_ready` = 0 for 3 cycles with a word pending → `out_data`/`out_id` stable, `req_ready` = 0. When `out_ready` is raised, the next requester in round-robin order is granted in that same cycle.
- Pointer wrap and skip: `NUM_REQUESTERS` = 3, with requesters 0 and 2 valid starting at `prio` = 0 → grants alternate 0,2,0,2 and `prio` wraps 1→0 correctly.
- Mid-operation reset: assert `rst_n` = 0 while `out_valid` = 1 and stalled → after the next edge, `out_valid` = 0 and `prio` = 0, and the stalled word is never delivered.
